// File: rtl/arbitro_rr4_if.sv
// Bus between the round-robin arbiter, its four input FIFOs and the
// downstream output FIFO. The master side is the arbiter itself.
interface arbitro_rr4_if #(
  parameter int WORD_SIZE = 12
);

  logic [WORD_SIZE-1:0] data_in_arb0;
  logic [WORD_SIZE-1:0] data_in_arb1;
  logic [WORD_SIZE-1:0] data_in_arb2;
  logic [WORD_SIZE-1:0] data_in_arb3;
  logic [3:0]           fifos_empty;
  logic                 fifo_almost_full;
  logic [3:0]           pop;
  logic [WORD_SIZE-1:0] data_out_arb;
  logic                 push;
  logic [4:0]           cuenta;
  logic [1:0]           estado;

  modport master (
    input  data_in_arb0, data_in_arb1, data_in_arb2, data_in_arb3,
    input  fifos_empty, fifo_almost_full,
    output pop, data_out_arb, push, cuenta, estado
  );

  modport slave (
    output data_in_arb0, data_in_arb1, data_in_arb2, data_in_arb3,
    output fifos_empty, fifo_almost_full,
    input  pop, data_out_arb, push, cuenta, estado
  );

endinterface

// File: rtl/arbitro_rr4.sv
// Four-input round-robin arbiter. Moves one word per cycle from the
// first-word-fall-through input FIFOs into a downstream FIFO, starting the
// search at the index after the last one served. Backpressure from the
// downstream FIFO blocks any pop in the same cycle.
module arbitro_rr4 #(
  parameter int WORD_SIZE = 12
) (
  input  logic           clk,
  input  logic           reset,
  arbitro_rr4_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [1:0]           r_ptr;
  logic [4:0]           r_cuenta;
  logic                 r_push;
  logic [WORD_SIZE-1:0] r_data;

  logic                 w_any_ready;
  logic                 w_grant;
  logic [1:0]           w_sel;
  logic                 w_found;
  logic [WORD_SIZE-1:0] w_sel_data;

  assign w_any_ready = (bus.fifos_empty != 4'b1111);
  // No grant while reset is high, and backpressure always wins over data.
  assign w_grant     = !reset && !bus.fifo_almost_full && w_any_ready;

  // Rotating priority search: first non-empty FIFO starting at r_ptr.
  always_comb begin
    logic [1:0] w_idx;
    w_sel   = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && !bus.fifos_empty[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // Head word of the selected FIFO.
  always_comb begin
    w_sel_data = bus.data_in_arb0;
    case (w_sel)
      2'd0:    w_sel_data = bus.data_in_arb0;
      2'd1:    w_sel_data = bus.data_in_arb1;
      2'd2:    w_sel_data = bus.data_in_arb2;
      default: w_sel_data = bus.data_in_arb3;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state depends only on the inputs; the unused code falls out naturally.
  always_comb begin
    w_next_state = IDLE;
    if (bus.fifo_almost_full) w_next_state = STALL;
    else if (w_any_ready)     w_next_state = ACTIVE;
    else                      w_next_state = IDLE;
  end

  // Output decode: one-hot pop of the selected FIFO during a grant cycle.
  always_comb begin
    bus.pop = 4'b0000;
    if (w_grant) bus.pop = 4'b0001 << w_sel;
  end

  // Registered datapath: capture the popped word, advance pointer and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_push   <= 1'b0;
      r_ptr    <= 2'd0;
      r_cuenta <= 5'd0;
    end else if (w_grant) begin
      r_data   <= w_sel_data;
      r_push   <= 1'b1;
      r_ptr    <= w_sel + 2'd1;
      r_cuenta <= r_cuenta + 5'd1;
    end else begin
      r_push   <= 1'b0;
    end
  end

  assign bus.data_out_arb = r_data;
  assign bus.push         = r_push;
  assign bus.cuenta       = r_cuenta;
  assign bus.estado       = r_state;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Self-checking bench for the four-input round-robin arbiter, with a
// behavioural model of pointer, count and output word kept in plain integers.
module tb_arbitro_rr4;

  localparam int W = 12;

  logic clk = 1'b0;
  logic reset;

  arbitro_rr4_if #(.WORD_SIZE(W)) bus ();

  arbitro_rr4 #(.WORD_SIZE(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         m_ptr;
  int         m_cuenta;
  int         m_estado;
  logic       m_push;
  logic [W-1:0] m_data;
  logic [W-1:0] din [4];
  bit         e_grant;
  int         e_sel;
  logic [3:0] e_pop;

  // Drive one cycle's inputs away from the rising edge and compute what pop must be.
  task automatic drive(input bit rst, input logic [3:0] emp, input bit af,
                       input logic [W-1:0] d0, d1, d2, d3);
    bit found;
    @(negedge clk);
    reset = rst;
    bus.fifos_empty      = emp;
    bus.fifo_almost_full = af;
    bus.data_in_arb0 = d0; bus.data_in_arb1 = d1;
    bus.data_in_arb2 = d2; bus.data_in_arb3 = d3;
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
    e_grant = !rst && !af && (emp != 4'hF);
    e_sel = 0;
    found = 0;
    if (e_grant) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && !emp[(m_ptr + k) % 4]) begin
          e_sel = (m_ptr + k) % 4;
          found = 1;
        end
      end
    end
    e_pop = e_grant ? (4'b0001 << e_sel) : 4'b0000;
    #1;
  endtask

  // Advance across the rising edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_push = 0; m_data = '0; m_cuenta = 0; m_ptr = 0; m_estado = 0;
    end else begin
      if (e_grant) begin
        m_push   = 1;
        m_data   = din[e_sel];
        m_ptr    = (e_sel + 1) % 4;
        m_cuenta = (m_cuenta + 1) % 32;
      end else begin
        m_push = 0;
      end
      if (bus.fifo_almost_full)         m_estado = 2;
      else if (bus.fifos_empty != 4'hF) m_estado = 1;
      else                              m_estado = 0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 4'h0, 0, 12'h111, 12'h222, 12'h333, 12'h444);
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'h0, 0, 12'hABC, 12'hABC, 12'hABC, 12'hABC);
      checks++;
      if (bus.pop !== 4'b0000) begin
        errors++; $display("[TB] FAIL reset_pop got=%b exp=0000", bus.pop);
      end
      tick();
    end
    checks++;
    if (bus.push !== 1'b0 || bus.data_out_arb !== 12'h000 || bus.cuenta !== 5'd0 || bus.estado !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_regs got push=%b data=%h cuenta=%0d estado=%b exp 0/000/0/00",
               bus.push, bus.data_out_arb, bus.cuenta, bus.estado);
    end
  endtask

  task automatic test_idle();
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 4'hF, 0, 12'h0, 12'h0, 12'h0, 12'h0);
      checks++;
      if (bus.pop !== 4'b0000) begin
        errors++; $display("[TB] FAIL idle_pop got=%b exp=0000", bus.pop);
      end
      tick();
    end
    checks++;
    if (bus.push !== 1'b0 || bus.estado !== 2'b00 || bus.cuenta !== 5'd0) begin
      errors++;
      $display("[TB] FAIL idle_regs got push=%b estado=%b cuenta=%0d exp 0/00/0",
               bus.push, bus.estado, bus.cuenta);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_pop;
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 4'h0, 0, 12'h0A0, 12'h0A1, 12'h0A2, 12'h0A3);
      exp_pop = 4'b0001 << (i % 4);
      checks++;
      if (bus.pop !== exp_pop) begin
        errors++; $display("[TB] FAIL fair_pop[%0d] got=%b exp=%b", i, bus.pop, exp_pop);
      end
      tick();
      checks++;
      if (bus.push !== 1'b1 || bus.data_out_arb !== W'(12'h0A0 + (i % 4))) begin
        errors++;
        $display("[TB] FAIL fair_data[%0d] got push=%b data=%h exp 1/%h",
                 i, bus.push, bus.data_out_arb, 12'h0A0 + (i % 4));
      end
    end
    checks++;
    if (bus.cuenta !== 5'd8 || bus.estado !== 2'b01) begin
      errors++; $display("[TB] FAIL fair_cuenta got=%0d/%b exp=8/01", bus.cuenta, bus.estado);
    end
  endtask

  task automatic test_single();
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b1011, 0, 12'h000, 12'h000, 12'h5C3, 12'h000);
      checks++;
      if (bus.pop !== 4'b0100) begin
        errors++; $display("[TB] FAIL single_pop[%0d] got=%b exp=0100", i, bus.pop);
      end
      tick();
      checks++;
      if (bus.push !== 1'b1 || bus.data_out_arb !== 12'h5C3) begin
        errors++;
        $display("[TB] FAIL single_push[%0d] got push=%b data=%h exp 1/5c3", i, bus.push, bus.data_out_arb);
      end
    end
    checks++;
    if (bus.cuenta !== 5'd3) begin
      errors++; $display("[TB] FAIL single_cuenta got=%0d exp=3", bus.cuenta);
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'h0, 0, 12'h100, 12'h101, 12'h102, 12'h103);
      tick();
    end
    drive(0, 4'h0, 1, 12'h100, 12'h101, 12'h102, 12'h103);
    checks++;
    if (bus.pop !== 4'b0000 || bus.push !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_first got pop=%b push=%b exp 0000/1", bus.pop, bus.push);
    end
    tick();
    checks++;
    if (bus.estado !== 2'b10 || bus.push !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_state got estado=%b push=%b exp 10/0", bus.estado, bus.push);
    end
    drive(0, 4'h0, 1, 12'h100, 12'h101, 12'h102, 12'h103);
    checks++;
    if (bus.pop !== 4'b0000) begin
      errors++; $display("[TB] FAIL stall_second got pop=%b exp=0000", bus.pop);
    end
    tick();
    drive(0, 4'h0, 0, 12'h100, 12'h101, 12'h102, 12'h103);
    checks++;
    if (bus.pop !== 4'b1000) begin
      errors++; $display("[TB] FAIL stall_resume got pop=%b exp=1000", bus.pop);
    end
    tick();
    checks++;
    if (bus.data_out_arb !== 12'h103 || bus.cuenta !== 5'd4 || bus.estado !== 2'b01) begin
      errors++;
      $display("[TB] FAIL stall_after got data=%h cuenta=%0d estado=%b exp 103/4/01",
               bus.data_out_arb, bus.cuenta, bus.estado);
    end
  endtask

  task automatic test_ptr2();
    do_reset(1);
    drive(0, 4'b1110, 0, 12'h010, 12'h011, 12'h012, 12'h013);
    tick();
    drive(0, 4'b1101, 0, 12'h010, 12'h011, 12'h012, 12'h013);
    tick();
    drive(0, 4'b0101, 0, 12'h010, 12'h011, 12'h012, 12'h013);
    checks++;
    if (bus.pop !== 4'b1000) begin
      errors++; $display("[TB] FAIL ptr2_first got pop=%b exp=1000", bus.pop);
    end
    tick();
    drive(0, 4'b0101, 0, 12'h010, 12'h011, 12'h012, 12'h013);
    checks++;
    if (bus.pop !== 4'b0010 || bus.data_out_arb !== 12'h013) begin
      errors++;
      $display("[TB] FAIL ptr2_second got pop=%b data=%h exp 0010/013", bus.pop, bus.data_out_arb);
    end
    tick();
  endtask

  task automatic test_wrap_and_reset();
    do_reset(1);
    for (int i = 0; i < 35; i++) begin
      drive(0, 4'h0, 0, 12'h7A0, 12'h7A1, 12'h7A2, 12'h7A3);
      tick();
    end
    checks++;
    if (bus.cuenta !== 5'd3 || bus.push !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_cuenta got=%0d push=%b exp 3/1", bus.cuenta, bus.push);
    end
    drive(1, 4'h0, 0, 12'h7A0, 12'h7A1, 12'h7A2, 12'h7A3);
    checks++;
    if (bus.pop !== 4'b0000) begin
      errors++; $display("[TB] FAIL midreset_pop got=%b exp=0000", bus.pop);
    end
    tick();
    checks++;
    if (bus.push !== 1'b0 || bus.cuenta !== 5'd0 || bus.data_out_arb !== 12'h000) begin
      errors++;
      $display("[TB] FAIL midreset_regs got push=%b cuenta=%0d data=%h exp 0/0/000",
               bus.push, bus.cuenta, bus.data_out_arb);
    end
  endtask

  task automatic test_random();
    bit rst, af;
    logic [3:0] emp;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      af  = ($urandom_range(0, 3) == 0);
      emp = 4'($urandom_range(0, 15));
      drive(rst, emp, af, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      checks++;
      if (bus.pop !== e_pop || (bus.pop & emp) !== 4'b0000) begin
        errors++; $display("[TB] FAIL rand_pop[%0d] got=%b exp=%b emp=%b", i, bus.pop, e_pop, emp);
      end
      tick();
      checks++;
      if (bus.push !== m_push || bus.data_out_arb !== m_data ||
          bus.cuenta !== 5'(m_cuenta) || bus.estado !== 2'(m_estado)) begin
        errors++;
        $display("[TB] FAIL rand_regs[%0d] got %b/%h/%0d/%b exp %b/%h/%0d/%0d", i,
                 bus.push, bus.data_out_arb, bus.cuenta, bus.estado,
                 m_push, m_data, m_cuenta, m_estado);
      end
    end
  endtask

  initial begin
    m_ptr = 0; m_cuenta = 0; m_estado = 0; m_push = 0; m_data = '0;
    reset = 1'b1;
    bus.fifos_empty = 4'hF;
    bus.fifo_almost_full = 1'b0;
    bus.data_in_arb0 = '0; bus.data_in_arb1 = '0;
    bus.data_in_arb2 = '0; bus.data_in_arb3 = '0;
    test_reset();
    test_idle();
    test_fairness();
    test_single();
    test_stall();
    test_ptr2();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
